escreveinstrucao: RTL and testbench

Serial program loader that writes the instruction memory read by the multicycle RISC-V core. It receives a UART 8N1 byte stream, assembles little-endian 32-bit instruction words, writes them into consecutive word addresses, and zero-fills the remaining words so the core's zero-instruction halt fires after the program. The core is held in reset until loading completes.

---
 rtl/escreveinstrucao.sv | 272 +++++++++++++++++++++++++++
 tb/tb_escreveinstrucao.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/escreveinstrucao.sv
// Serial program loader: UART 8N1 bytes -> little-endian words -> instruction memory, then zero-fill.
// Latency: byte ready ~2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after start edge; imem_we one cycle after 4th byte.
// Backpressure: none; rx cannot be stalled, memory accepts one write per cycle, at most one word write per byte time.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx              UART receive line (idle high, asynchronous to clk)
//   imem_we         one-cycle instruction memory write strobe
//   imem_addr       word address of the write
//   imem_wdata      word written
//   core_rst        holds the core in reset until the program is loaded
//   done            program loaded, core released (sticky until rst)
//   error           sticky load failure (bad count, framing error, bad checksum)
//
// Build option: define ESCREVEINSTRUCAO_CHECKSUM_EN to expect a trailing XOR checksum
// byte over all data bytes; without it, the byte after the data is ignored.

module escreveinstrucao #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 32,
  parameter int AW           = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst,
  output logic          done,
  output logic          error
);

  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // rx synchronizer (rx_m, rx_s) plus one history flop (rx_d) for edge detect
  // ---------------------------------------------------------------------------
  logic rx_m, rx_s, rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  rx_state_t     rx_st;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_sr;      // holds the received byte while byte_vld is high
  logic          byte_vld;
  logic          frame_err;

  always_ff @(posedge clk) begin
    byte_vld  <= 1'b0;
    frame_err <= 1'b0;
    if (rst) begin
      rx_st   <= R_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      rx_sr   <= '0;
    end else begin
      case (rx_st)
        R_IDLE: begin
          if (rx_d && !rx_s) begin
            rx_st   <= R_START;
            bit_cnt <= '0;
          end
        end
        R_START: begin
          // Mid start bit: a line that is high again was only a glitch.
          if (bit_cnt == HALF_M1) begin
            bit_cnt <= '0;
            if (rx_s) begin
              rx_st <= R_IDLE;
            end else begin
              rx_st   <= R_DATA;
              bit_idx <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt <= '0;
            rx_sr   <= {rx_s, rx_sr[7:1]};   // LSB arrives first
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              rx_st <= R_STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_STOP: begin
          // Returning to idle mid stop bit leaves half a bit of margin for
          // the next start edge, so back-to-back bytes are accepted.
          if (bit_cnt == FULL_M1) begin
            bit_cnt   <= '0;
            rx_st     <= R_IDLE;
            byte_vld  <= rx_s;
            frame_err <= !rx_s;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM (all outputs registered)
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_FILL,
    S_DONE,
    S_ERR
  } state_t;

  state_t      st;
  logic [AW:0] n_words;    // N, 1..DEPTH
  logic [AW:0] word_idx;   // index of the word being assembled
  logic [1:0]  byte_idx;
  logic [23:0] word_sr;    // first three bytes of the current word
`ifdef ESCREVEINSTRUCAO_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  always_ff @(posedge clk) begin
    imem_we <= 1'b0;
    if (rst) begin
      st         <= S_IDLE;
      n_words    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef ESCREVEINSTRUCAO_CHECKSUM_EN
      csum       <= '0;
`endif
    end else if (frame_err && st != S_DONE && st != S_ERR) begin
      st    <= S_ERR;
      error <= 1'b1;
    end else begin
      case (st)
        S_IDLE: begin
          if (byte_vld) begin
            if (rx_sr == 8'd0 || {1'b0, rx_sr} > 9'(DEPTH)) begin
              st    <= S_ERR;
              error <= 1'b1;
            end else begin
              n_words  <= (AW + 1)'(rx_sr);
              word_idx <= '0;
              byte_idx <= '0;
              st       <= S_RECV;
            end
          end
        end

        S_RECV: begin
          if (byte_vld) begin
            byte_idx <= byte_idx + 1'b1;
`ifdef ESCREVEINSTRUCAO_CHECKSUM_EN
            csum     <= csum ^ rx_sr;
`endif
            if (byte_idx == 2'd3) begin
              st         <= S_WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[AW-1:0];
              imem_wdata <= {rx_sr, word_sr};
            end else begin
              word_sr <= {rx_sr, word_sr[23:8]};
            end
          end
        end

        // The write strobe is already on the bus during this cycle.
        S_WRITE: begin
          word_idx <= word_idx + 1'b1;
          if (word_idx + 1'b1 != n_words) begin
            st <= S_RECV;
          end else begin
`ifdef ESCREVEINSTRUCAO_CHECKSUM_EN
            st <= S_CHECK;
`else
            if (n_words == DEPTH_W) begin
              st       <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              st         <= S_FILL;
              imem_we    <= 1'b1;
              imem_addr  <= n_words[AW-1:0];
              imem_wdata <= '0;
            end
`endif
          end
        end

`ifdef ESCREVEINSTRUCAO_CHECKSUM_EN
        S_CHECK: begin
          if (byte_vld) begin
            if (rx_sr != csum) begin
              st    <= S_ERR;
              error <= 1'b1;
            end else if (n_words == DEPTH_W) begin
              st       <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              st         <= S_FILL;
              imem_we    <= 1'b1;
              imem_addr  <= n_words[AW-1:0];
              imem_wdata <= '0;
            end
          end
        end
`endif

        // One zero word per cycle; the write for imem_addr is on the bus now.
        S_FILL: begin
          if (imem_addr == LAST_ADDR) begin
            st       <= S_DONE;
            done     <= 1'b1;
            core_rst <= 1'b0;
          end else begin
            imem_we   <= 1'b1;
            imem_addr <= imem_addr + 1'b1;
          end
        end

        S_DONE: st <= S_DONE;
        S_ERR:  st <= S_ERR;
        default: begin
          st    <= S_ERR;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_escreveinstrucao.sv
// Bench for escreveinstrucao: table of whole load frames plus hand-written
// glitch, mid-frame reset and full-depth sequences. CLKS_PER_BIT=16.

module tb_escreveinstrucao;

  localparam int CPB   = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  escreveinstrucao #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH),
    .AW          (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  // Memory observer: rebuilt from the write strobes, cleared while rst is high.
  logic [31:0] mem_seen [DEPTH];
  int          we_cnt;
  int          last_we_cyc;
  int          done_cyc;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_seen[i] = 32'hBAD0BAD0;
      we_cnt      = 0;
      last_we_cyc = -1;
      done_cyc    = -1;
    end else begin
      if (imem_we) begin
        mem_seen[imem_addr] = imem_wdata;
        we_cnt++;
        last_we_cyc = cyc;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Frame bytes are packed first-byte-in-LSB: byte i = bytes[8*i +: 8].
  typedef struct {
    int          nb;
    logic [79:0] bytes;
    int          bad_idx;   // byte sent with stop bit 0, -1 for none
    int          n;
    logic        exp_done;
    logic        exp_err;
    int          exp_we;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

`ifdef ESCREVEINSTRUCAO_CHECKSUM_EN
  localparam int NV = 7;
`else
  localparam int NV = 5;
`endif

  vec_t vecs [NV];

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    logic        ok;

    // Trailing 0x61 = XOR of 93 00 50 00 33 81 10 00 (checksum, or ignored byte).
    vecs[0] = '{10, 80'h61_00_10_81_33_00_50_00_93_02, -1, 2, 1'b1, 1'b0, 32,
                32'h00500093, 32'h00108133};
    // Stop bit 0 on the 3rd data byte: no word ever completes.
    vecs[1] = '{10, 80'h61_00_10_81_33_00_50_00_93_02, 3, 2, 1'b0, 1'b1, 0,
                32'h0, 32'h0};
    vecs[2] = '{1, 80'h00, -1, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[3] = '{1, 80'h21, -1, 33, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    // 0x22 = EF^BE^AD^DE.
    vecs[4] = '{6, 80'h22_DE_AD_BE_EF_01, -1, 1, 1'b1, 1'b0, 32,
                32'hDEADBEEF, 32'h0};
`ifdef ESCREVEINSTRUCAO_CHECKSUM_EN
    vecs[5] = '{6, 80'h13_00_00_00_13_01, -1, 1, 1'b1, 1'b0, 32,
                32'h00000013, 32'h0};
    vecs[6] = '{6, 80'h12_00_00_00_13_01, -1, 1, 1'b0, 1'b1, 1,
                32'h00000013, 32'h0};
`endif

    // ---- reset values ----
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset imem_we",    32'(imem_we),    32'h0);
    chk("reset imem_addr",  32'(imem_addr),  32'h0);
    chk("reset imem_wdata", imem_wdata,      32'h0);
    chk("reset core_rst",   32'(core_rst),   32'h1);
    chk("reset done",       32'(done),       32'h0);
    chk("reset error",      32'(error),      32'h0);

    // ---- table of complete frames ----
    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].nb; i++)
        send_byte(vecs[v].bytes[8*i +: 8], (i != vecs[v].bad_idx));
      repeat (100) @(posedge clk);
      #1;
      chk($sformatf("v%0d done", v),     32'(done),     32'(vecs[v].exp_done));
      chk($sformatf("v%0d error", v),    32'(error),    32'(vecs[v].exp_err));
      chk($sformatf("v%0d core_rst", v), 32'(core_rst), 32'(!vecs[v].exp_done));
      chk($sformatf("v%0d we_count", v), we_cnt,        vecs[v].exp_we);
      if (vecs[v].exp_we > 0)
        chk($sformatf("v%0d word0", v), mem_seen[0], vecs[v].exp_w0);
      if (vecs[v].exp_we == DEPTH) begin
        chk($sformatf("v%0d word1", v), mem_seen[1], vecs[v].exp_w1);
        ok = 1'b1;
        for (int a = vecs[v].n; a < DEPTH; a++)
          if (mem_seen[a] !== 32'h0) ok = 1'b0;
        chk($sformatf("v%0d fill_zero", v), 32'(ok), 32'h1);
        chk($sformatf("v%0d done_lag", v), done_cyc - last_we_cyc, 32'd1);
      end
    end

    // ---- glitch: 4 low cycles, then a normal frame ----
    do_reset();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    rx = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("glitch we_count", we_cnt,         32'd0);
    chk("glitch error",    32'(error),     32'h0);
    chk("glitch done",     32'(done),      32'h0);
    chk("glitch core_rst", 32'(core_rst),  32'h1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    chk("glitch word0", mem_seen[0], 32'hDEADBEEF);
    chk("glitch after done", 32'(done), 32'h1);

    // ---- reset after 5 bytes of an N=2 frame, mid 6th byte ----
    do_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h93, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h50, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid first word", mem_seen[0], 32'h00500093);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid rst imem_we",    32'(imem_we),   32'h0);
    chk("mid rst imem_addr",  32'(imem_addr), 32'h0);
    chk("mid rst imem_wdata", imem_wdata,     32'h0);
    chk("mid rst core_rst",   32'(core_rst),  32'h1);
    chk("mid rst done",       32'(done),      32'h0);
    chk("mid rst error",      32'(error),     32'h0);
    chk("mid rst no write",   we_cnt,         32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    send_byte(8'h01, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    chk("mid fresh word0",    mem_seen[0], 32'hDEADBEEF);
    chk("mid fresh we_count", we_cnt,      32'd32);
    chk("mid fresh done",     32'(done),   32'h1);

    // ---- N = DEPTH: no fill phase ----
    do_reset();
    send_byte(8'h20, 1'b1);
    cs = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'hC0DE0000 | 32'(i);
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], 1'b1);
        cs = cs ^ w[8*b +: 8];
      end
    end
`ifdef ESCREVEINSTRUCAO_CHECKSUM_EN
    send_byte(cs, 1'b1);
`endif
    repeat (100) @(posedge clk);
    #1;
    chk("full we_count", we_cnt,          32'd32);
    chk("full done",     32'(done),       32'h1);
    chk("full error",    32'(error),      32'h0);
    chk("full last_addr", 32'(imem_addr), 32'd31);
    ok = 1'b1;
    for (int a = 0; a < DEPTH; a++)
      if (mem_seen[a] !== (32'hC0DE0000 | 32'(a))) ok = 1'b0;
    chk("full contents", 32'(ok), 32'h1);
`ifndef ESCREVEINSTRUCAO_CHECKSUM_EN
    chk("full done_lag", done_cyc - last_we_cyc, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
